vga_pixel_pipe: RTL and testbench
=================================

VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

Interface
REQ-001 clk  input  1  25 MHz pixel clock; the same clock drives the timing generator and the image ROM.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 h_cnt  input  10  column from the timing generator, 0..639 when active.
REQ-004 v_cnt  input  10  line from the timing generator, 0..479 when active.
REQ-005 valid  input  1  active-video flag from the timing generator.
REQ-006 hsync_i, vsync_i  input  1 each  raw syncs, active-low.
REQ-007 pixel  input  12  ROM read data {R,G,B}; it arrives one clk after the h_cnt/v_cnt that addressed it.
REQ-008 mode  input  3  effect state from the address generator; encoding is in the shared package.
REQ-009 count  input  10  effect progress value from the address generator.
REQ-010 vgaRed, vgaGreen, vgaBlue  output  4 each  registered colour.
REQ-011 hsync, vsync  output  1 each  syncs delayed to match the colour outputs.
REQ-012 frame_start  output  1  one-clk pulse on each vsync_i falling edge.
REQ-013 frame_cnt  output  8  count of completed frames.

Function
REQ-014 Total latency from h_cnt/v_cnt/valid/syncs to colour/sync outputs SHALL be exactly 2 clk.
REQ-015 Stage 1 SHALL register h_cnt, v_cnt, valid, hsync_i and vsync_i so they align with pixel.
REQ-016 Stage 2 SHALL register the masked colour and the stage-1 syncs.
REQ-017 mode and count SHALL be captured into shadow registers only on the vsync_i falling edge; they are held for the whole frame, so no tearing occurs.
REQ-018 Colour SHALL be 0x000 whenever the stage-1 valid is 0, regardless of mode.
REQ-019 INITIAL: output = pixel.
REQ-020 SHIFT_LEFT: output = pixel if h < 640 - count, else black; count >= 640 gives an all-black frame (compare in 11 bits, no underflow).
REQ-021 SHIFT_DOWN: output = pixel if v <= count, else black.
REQ-022 SPLIT: c = min(count, 320); columns h in [320 - c, 320 + c) are black and the rest show pixel; c = 0 shows the full image.
REQ-023 An undefined mode encoding SHALL give black.
REQ-024 Edge detect SHALL compare vsync_i with its stage-1 copy; frame_start is asserted in the cycle the stage-1 copy is 1 and the input is 0.
REQ-025 frame_cnt SHALL increment on frame_start and wrap from 255 to 0.
REQ-026 A mode/count change mid-frame SHALL NOT affect output until the next vsync_i falling edge.

Reset
REQ-027 Reset values:
- all pipeline registers 0, except the stage-1 sync copies, which are 1
- hsync and vsync outputs 1
- colour outputs 0
- shadow mode = INITIAL, shadow count = 0
- frame_start 0, frame_cnt 0
REQ-028 Reset asserted mid-line SHALL force these values immediately, with no clock edge needed.
REQ-029 After reset release, no frame_start SHALL occur until vsync_i has been seen high and then low.

Structure
REQ-030 The shared package SHALL hold the mode encodings (INITIAL = 1, SHIFT_LEFT = 2, SHIFT_DOWN = 3, SPLIT = 4) and the constants H_ACTIVE = 640, V_ACTIVE = 480 and H_MID = 320.
REQ-031 One sub-module, pixel_mask, SHALL be the purely combinational mode/count/h/v-to-keep decision; all registers stay in vga_pixel_pipe.

Verification
REQ-032 INITIAL, pixel = 0xABC held constant, valid = 1 -> {vgaRed, vgaGreen, vgaBlue} = 0xABC exactly 2 clk after valid rises; hsync/vsync equal the inputs delayed by 2 clk.
REQ-033 SHIFT_LEFT, count = 600 latched at frame start -> h 0..39 show pixel, h 40..639 black; count = 700 -> entire frame black.
REQ-034 SHIFT_DOWN, count = 100 -> lines 0..100 show pixel, lines 101..479 black; valid = 0 on any line -> 0x000.
REQ-035 SPLIT, count = 50 -> h 270..369 black, h 269 and h 370 show pixel; count = 400 -> whole frame black.
REQ-036 mode changed INITIAL -> SHIFT_LEFT at line 200 -> output unchanged through line 479, effect begins after the next vsync_i fall; frame_start pulses once per frame; frame_cnt wraps 255 -> 0.
REQ-037 rst pulsed mid-line (between clk edges) -> outputs 0 / syncs 1 at once, and frame_cnt = 0.

Source files
------------

// File: rtl/vga_pixel_pipe_pkg.sv
// Shared definitions for the VGA pixel pipeline: effect mode encodings and
// active-area geometry.
package vga_pixel_pipe_pkg;

  typedef enum logic [2:0] {
    MODE_INITIAL    = 3'd1,
    MODE_SHIFT_LEFT = 3'd2,
    MODE_SHIFT_DOWN = 3'd3,
    MODE_SPLIT      = 3'd4
  } mode_e;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_MID    = 320;

  // Half-width of the split band, saturated so the band never leaves the screen.
  function automatic logic [9:0] split_half(input logic [9:0] count);
    return (count > 10'(H_MID)) ? 10'(H_MID) : count;
  endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Bundle of timing-generator, ROM and effect inputs plus the VGA outputs.
// The master drives the timing/ROM side; the slave is the pixel pipeline.
interface vga_pixel_pipe_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        hsync_i;
  logic        vsync_i;
  logic [11:0] pixel;
  logic [2:0]  mode;
  logic [9:0]  count;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  modport master (
    output h_cnt, v_cnt, valid, hsync_i, vsync_i, pixel, mode, count,
    input  vgaRed, vgaGreen, vgaBlue, hsync, vsync, frame_start, frame_cnt
  );

  modport slave (
    input  h_cnt, v_cnt, valid, hsync_i, vsync_i, pixel, mode, count,
    output vgaRed, vgaGreen, vgaBlue, hsync, vsync, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_pixel_pipe_pixel_mask.sv
// Combinational keep/black decision for one pixel given the frame's latched
// effect mode and progress count.
module pixel_mask
  import vga_pixel_pipe_pkg::*;
(
  input  logic [2:0] mode_i,
  input  logic [9:0] count_i,
  input  logic [9:0] h_i,
  input  logic [9:0] v_i,
  output logic       keep_o
);

  logic [10:0] h_ext;
  logic [10:0] left_sum;
  logic [10:0] half_ext;
  logic [10:0] band_lo;
  logic [10:0] band_hi;

  always_comb begin
    h_ext    = {1'b0, h_i};
    // h < 640 - count rewritten as h + count < 640 so large counts cannot underflow
    left_sum = h_ext + {1'b0, count_i};
    half_ext = {1'b0, split_half(count_i)};
    band_lo  = 11'(H_MID) - half_ext;
    band_hi  = 11'(H_MID) + half_ext;
    keep_o   = 1'b0;
    case (mode_i)
      MODE_INITIAL:    keep_o = 1'b1;
      MODE_SHIFT_LEFT: keep_o = (left_sum < 11'(H_ACTIVE));
      MODE_SHIFT_DOWN: keep_o = (v_i <= count_i);
      MODE_SPLIT:      keep_o = (h_ext < band_lo) || (h_ext >= band_hi);
      default:         keep_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vga_pixel_pipe.sv
// Two-stage VGA pixel pipeline: aligns timing with ROM data, applies the
// per-frame effect mask, and tracks frame boundaries.
module vga_pixel_pipe
  import vga_pixel_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  vga_pixel_pipe_if.slave  bus
);

  logic [9:0]  h1_q, v1_q;
  logic        valid1_q, hs1_q, vs1_q;
  logic        seen_high_q;
  logic [2:0]  mode_q;
  logic [9:0]  count_q;
  logic [11:0] rgb_q;
  logic        hs2_q, vs2_q;
  logic [7:0]  frame_cnt_q;

  logic        keep;
  logic        frame_start_d;
  logic [11:0] rgb_d;
  logic [7:0]  frame_cnt_d;

  pixel_mask u_mask (
    .mode_i  (mode_q),
    .count_i (count_q),
    .h_i     (h1_q),
    .v_i     (v1_q),
    .keep_o  (keep)
  );

  // The stage-1 vsync copy resets high, so a low vsync right after reset
  // must not count as a fall until a real high level has been seen.
  assign frame_start_d = seen_high_q & vs1_q & ~bus.vsync_i;
  assign rgb_d         = (valid1_q && keep) ? bus.pixel : 12'h000;
  assign frame_cnt_d   = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q        <= '0;
      v1_q        <= '0;
      valid1_q    <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      seen_high_q <= 1'b0;
      mode_q      <= MODE_INITIAL;
      count_q     <= '0;
      rgb_q       <= '0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      h1_q        <= bus.h_cnt;
      v1_q        <= bus.v_cnt;
      valid1_q    <= bus.valid;
      hs1_q       <= bus.hsync_i;
      vs1_q       <= bus.vsync_i;
      seen_high_q <= seen_high_q | bus.vsync_i;
      if (frame_start_d) begin
        mode_q  <= bus.mode;
        count_q <= bus.count;
      end
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
    end
  end

  assign bus.vgaRed      = rgb_q[11:8];
  assign bus.vgaGreen    = rgb_q[7:4];
  assign bus.vgaBlue     = rgb_q[3:0];
  assign bus.hsync       = hs2_q;
  assign bus.vsync       = vs2_q;
  assign bus.frame_start = frame_start_d;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe with a scoreboard of expected pixel/sync
// outputs and a reference model of the frame shadow registers.
module tb_vga_pixel_pipe;
  import vga_pixel_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  vga_pixel_pipe_if bus ();

  vga_pixel_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb[$];

  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  m_mode;
  int          m_count;
  bit          m_prev_vs;
  bit          m_seen;
  int          m_fcnt;
  logic [11:0] pend_pix;

  function automatic bit keep_model(input logic [2:0] m, input int c, input int h, input int v);
    int half;
    half = (c < 320) ? c : 320;
    case (m)
      3'd1:    return 1'b1;
      3'd2:    return h < 640 - c;
      3'd3:    return v <= c;
      3'd4:    return !((h >= 320 - half) && (h < 320 + half));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] pix_of(input int h, input int v);
    return 12'(h * 37 + v * 91) | 12'h001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 3'd1;
    m_count   = 0;
    m_prev_vs = 1'b1;
    m_seen    = 1'b0;
    m_fcnt    = 0;
    sb.delete();
    sb.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
  endtask

  task automatic check_reset_state();
    check("rst_rgb", {20'h0, bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, 32'h0);
    check("rst_hsync", {31'h0, bus.hsync}, 32'h1);
    check("rst_vsync", {31'h0, bus.vsync}, 32'h1);
    check("rst_frame_start", {31'h0, bus.frame_start}, 32'h0);
    check("rst_frame_cnt", {24'h0, bus.frame_cnt}, 32'h0);
  endtask

  // One pixel clock: drive address/syncs, feed last cycle's ROM data, check outputs.
  task automatic step(input int h, input int v, input bit val, input bit hs, input bit vs,
                      input logic [11:0] pix);
    exp_t e;
    bit   fall;
    @(negedge clk);
    bus.h_cnt   = 10'(h);
    bus.v_cnt   = 10'(v);
    bus.valid   = val;
    bus.hsync_i = hs;
    bus.vsync_i = vs;
    bus.pixel   = pend_pix;
    pend_pix    = pix;
    fall = m_seen && m_prev_vs && !vs;
    if (fall) begin
      m_mode  = bus.mode;
      m_count = int'(bus.count);
      m_fcnt  = (m_fcnt + 1) % 256;
    end
    if (vs) m_seen = 1'b1;
    m_prev_vs = vs;
    e.rgb = (val && keep_model(m_mode, m_count, h, v)) ? pix : 12'h000;
    e.hs  = hs;
    e.vs  = vs;
    sb.push_back(e);
    #1;
    check("frame_start", {31'h0, bus.frame_start}, {31'h0, fall});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("rgb", {20'h0, bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, {20'h0, e.rgb});
    check("hsync", {31'h0, bus.hsync}, {31'h0, e.hs});
    check("vsync", {31'h0, bus.vsync}, {31'h0, e.vs});
    check("frame_cnt", {24'h0, bus.frame_cnt}, 32'(m_fcnt));
  endtask

  task automatic px(input int h, input int v);
    step(h, v, 1'b1, h[0], 1'b1, pix_of(h, v));
  endtask

  task automatic scan(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) px(h, v);
  endtask

  // Vsync fall latches m/c; the inputs are then scrambled to prove shadowing.
  task automatic new_frame(input logic [2:0] m, input int c);
    bus.mode  = m;
    bus.count = 10'(c);
    step(0, 490, 1'b0, 1'b1, 1'b0, 12'h000);
    bus.mode  = 3'd7;
    bus.count = 10'($urandom_range(0, 1023));
    step(0, 491, 1'b0, 1'b1, 1'b0, 12'h000);
    step(0, 492, 1'b0, 1'b1, 1'b1, 12'h000);
  endtask

  initial begin
    bus.h_cnt = '0; bus.v_cnt = '0; bus.valid = 1'b0;
    bus.hsync_i = 1'b1; bus.vsync_i = 1'b1; bus.pixel = '0;
    bus.mode = MODE_INITIAL; bus.count = '0;
    pend_pix = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    model_reset();

    // Constant 0xABC appears two clocks after valid rises; syncs follow by two.
    step(0, 0, 1'b0, 1'b1, 1'b1, 12'hABC);
    step(0, 0, 1'b0, 1'b0, 1'b1, 12'hABC);
    for (int h = 0; h < 6; h++) step(h, 0, 1'b1, h[1], 1'b1, 12'hABC);

    new_frame(MODE_SHIFT_LEFT, 600);
    scan(5, 37, 42);
    px(639, 5);
    new_frame(MODE_SHIFT_LEFT, 700);
    px(0, 0); px(1, 0); px(639, 479);

    new_frame(MODE_SHIFT_DOWN, 100);
    px(10, 0); px(10, 99); px(10, 100); px(10, 101); px(10, 479);
    step(10, 50, 1'b0, 1'b1, 1'b1, pix_of(10, 50));

    new_frame(MODE_SPLIT, 50);
    px(0, 7); scan(7, 268, 271); px(300, 7); scan(7, 368, 371); px(639, 7);
    new_frame(MODE_SPLIT, 400);
    px(0, 8); px(319, 8); px(320, 8); px(639, 8);
    new_frame(MODE_SPLIT, 0);
    px(319, 9); px(320, 9);

    new_frame(3'd7, 5);
    px(0, 3); px(320, 3);

    // Mid-frame mode change only takes effect after the next vsync fall.
    new_frame(MODE_INITIAL, 0);
    px(100, 199);
    bus.mode = MODE_SHIFT_LEFT; bus.count = 10'd600;
    px(100, 200); px(100, 479);
    step(0, 490, 1'b0, 1'b1, 1'b0, 12'h000);
    step(0, 491, 1'b0, 1'b1, 1'b1, 12'h000);
    px(100, 0); px(20, 0);

    for (int f = 0; f < 256; f++) begin
      step(0, 500, 1'b0, 1'b1, 1'b1, 12'h000);
      step(0, 500, 1'b0, 1'b1, 1'b0, 12'h000);
    end
    step(0, 500, 1'b0, 1'b1, 1'b1, 12'h000);
    new_frame(MODE_INITIAL, 0);
    px(5, 5); px(6, 5);

    // Asynchronous reset between clock edges while a pixel is in flight.
    @(negedge clk);
    bus.valid = 1'b1; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
    step(0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
    step(0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
    px(1, 1); px(2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
